// File: rtl/incr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : incr_arbiter_pkg
// Purpose  : Shared defaults and types for the incr_arbiter block.
//            - NREQ_DEF / WIDTH_DEF : default requester count and data width
//            - req_id_t             : requester index for the default NREQ
//            - stage_t              : pipeline stage record (valid, id, data)
//              laid out for the default configuration
// Revision : 1.0 - initial release
// ============================================================================
package incr_arbiter_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;
  localparam int ID_W_DEF  = $clog2(NREQ_DEF);

  typedef logic [ID_W_DEF-1:0] req_id_t;

  typedef struct packed {
    logic                 valid;
    req_id_t              id;
    logic [WIDTH_DEF-1:0] data;
  } stage_t;

endpackage : incr_arbiter_pkg
`default_nettype wire

// File: rtl/incr_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Purpose  : Purely combinational round-robin selector. The search starts at
//            ptr_i and wraps past NREQ-1 back to 0; the first requesting index
//            wins.
// Ports    : req_i   - request vector
//            ptr_i   - search start index
//            gnt_o   - one-hot winner (zero when no request)
//            idx_o   - binary index of the winner
//            valid_o - some request was found
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            valid_o
);

  always_comb begin
    int k;
    k       = 0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    // Walk the requesters in priority order starting at ptr_i.
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(ptr_i) + i) % NREQ;
      if (!valid_o && req_i[k]) begin
        valid_o  = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IDW'(k);
      end
    end
  end

endmodule : rr_picker
`default_nettype wire

// File: rtl/incr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : incr_arbiter
// Purpose  : Round-robin arbiter feeding one shared two-stage increment
//            pipeline. Stage 1 registers the granted operand, stage 2
//            registers operand+1. The requester index travels with the data.
//            The whole pipeline holds while a result is presented and not
//            accepted.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req, req_data       - per-requester request and operand
//            gnt                 - one-hot grant (operand captured this cycle)
//            rsp_valid/rsp_ready - result handshake
//            rsp_id, rsp_data    - result owner and incremented operand
// Config   : INCR_ARBITER_SAT_EN - when defined the increment saturates at
//            all-ones; otherwise it wraps modulo 2^WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module incr_arbiter
  import incr_arbiter_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0][WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            gnt,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [WIDTH-1:0]           rsp_data
);

  localparam int IDW = $clog2(NREQ);

  // Stage record sized for this instance's parameters.
  typedef struct packed {
    logic             valid;
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] data;
  } pipe_t;

  pipe_t          s1_q, s1_d;
  pipe_t          s2_q, s2_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_idx;
  logic            pick_valid;
  logic            advance;
  logic            grant;
  logic [WIDTH-1:0] inc_data;

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Every stage moves together; only an unaccepted result can block it.
  assign advance = !s2_q.valid || rsp_ready;
  // No grant while in reset, so nothing is captured that reset would discard.
  assign grant   = advance && pick_valid && !rst;
  assign gnt     = grant ? pick_gnt : '0;

`ifdef INCR_ARBITER_SAT_EN
  assign inc_data = (&s1_q.data) ? s1_q.data : s1_q.data + WIDTH'(1);
`else
  assign inc_data = s1_q.data + WIDTH'(1);
`endif

  always_comb begin
    s1_d  = s1_q;
    s2_d  = s2_q;
    ptr_d = ptr_q;
    if (advance) begin
      // A cycle without a grant loads a bubble into stage 1.
      s1_d.valid = grant;
      s1_d.id    = pick_idx;
      s1_d.data  = req_data[pick_idx];
      s2_d.valid = s1_q.valid;
      s2_d.id    = s1_q.id;
      s2_d.data  = inc_data;
    end
    if (grant) begin
      ptr_d = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      ptr_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      ptr_q <= ptr_d;
    end
  end

  // Outputs are forced to zero for the whole reset cycle, not only after it.
  assign rsp_valid = s2_q.valid && !rst;
  assign rsp_id    = rst ? '0 : s2_q.id;
  assign rsp_data  = rst ? '0 : s2_q.data;

endmodule : incr_arbiter
`default_nettype wire
